// File: rtl/mem_slave_writer_if.sv
// FIFO read-side and memory readback signals shared by mem_slave_writer and its driver.
interface mem_slave_writer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_r_en;
  logic                  mem_clr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH:0]   mem_count;
  logic                  mem_full;
  logic                  busy;

  modport slave (
    input  fifo_empty, fifo_data_out, mem_clr, rd_addr,
    output fifo_r_en, rd_data, mem_count, mem_full, busy
  );

  modport master (
    output fifo_empty, fifo_data_out, mem_clr, rd_addr,
    input  fifo_r_en, rd_data, mem_count, mem_full, busy
  );
endinterface

// File: rtl/mem_slave_writer.sv
// Pops bytes from the async FIFO read port into a register-file memory (clk_mem domain).
// Define MEM_WRAP_EN for ring-buffer mode: never full, oldest words overwritten.
module mem_slave_writer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input logic               clk_mem,
  input logic               reset,
  mem_slave_writer_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StCapt  = 2'd2;
  localparam logic [1:0] StStore = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  full;
  logic                  store_en;

`ifdef MEM_WRAP_EN
  assign full = 1'b0;
`else
  assign full = (count_q == FULL_COUNT);
`endif

  // mem_clr wins over a pending STORE, so the word in flight is dropped.
  assign store_en = (state_q == StStore) && !bus.mem_clr;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    case (state_q)
      StIdle: begin
        if (!bus.fifo_empty && !full) state_d = StReq;
      end
      StReq:  state_d = StCapt;
      StCapt: state_d = StStore;
      StStore: begin
        state_d  = StIdle;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q != FULL_COUNT) count_d = count_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (bus.mem_clr) begin
      state_d  = StIdle;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_mem or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rd_data_q <= mem[bus.rd_addr];
      if (state_q == StCapt) data_q <= bus.fifo_data_out;
    end
  end

  // Storage is deliberately not reset; a read of the write address returns old contents.
  always_ff @(posedge clk_mem) begin
    if (store_en) mem[wr_ptr_q] <= data_q;
  end

  assign bus.fifo_r_en = (state_q == StReq);
  assign bus.busy      = (state_q != StIdle);
  assign bus.mem_count = count_q;
  assign bus.mem_full  = full;
  assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_mem_slave_writer.sv
// Self-checking bench for mem_slave_writer: FIFO model, pop scoreboard and readback tables.
module tb_mem_slave_writer;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  logic clk;
  logic rst;

  mem_slave_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_slave_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_mem (clk),
    .reset   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dbl = 0;
  int underflow = 0;
  logic prev_pop = 1'b0;
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q [$];
  int pop_cyc [$];
  logic [DW-1:0] model_mem [DEPTH];
  int model_ptr = 0;
  int model_cnt = 0;
  vec_t fill_vec [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: FIFO model pops on a sampled r_en, data appears just after the edge.
  task automatic tick();
    logic pop;
    pop = bus.fifo_r_en;
    @(posedge clk);
    #1;
    cyc++;
    if (pop === 1'b1) begin
      if (prev_pop === 1'b1) dbl++;
      pop_cyc.push_back(cyc);
      if (fifo_q.size() == 0) underflow++;
      else begin
        bus.fifo_data_out = fifo_q.pop_front();
        exp_q.push_back(bus.fifo_data_out);
      end
    end
    prev_pop = pop;
    bus.fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((bus.busy || (!bus.fifo_empty && !bus.mem_full)) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_settle"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (!bus.fifo_r_en && n < budget) begin
      tick();
      n++;
    end
    check({name, "_req"}, 32'(n < budget), 32'd1);
  endtask

  task automatic drain_model();
    while (exp_q.size() > 0) begin
      model_mem[model_ptr] = exp_q.pop_front();
      model_ptr = (model_ptr + 1) % DEPTH;
      if (model_cnt < DEPTH) model_cnt++;
    end
  endtask

  task automatic readback(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    bus.rd_addr = addr;
    tick();
    data = bus.rd_data;
  endtask

  task automatic clear_mem();
    bus.mem_clr = 1'b1;
    tick();
    bus.mem_clr = 1'b0;
    model_ptr = 0;
    model_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    int seen;
    int hits;
`ifdef MEM_WRAP_EN
    fill_vec[0] = '{addr: 4'd0,  data: 8'h10};
    fill_vec[1] = '{addr: 4'd3,  data: 8'h13};
    fill_vec[2] = '{addr: 4'd4,  data: 8'h04};
    fill_vec[3] = '{addr: 4'd15, data: 8'h0F};
`else
    fill_vec[0] = '{addr: 4'd0,  data: 8'h00};
    fill_vec[1] = '{addr: 4'd5,  data: 8'h05};
    fill_vec[2] = '{addr: 4'd8,  data: 8'h08};
    fill_vec[3] = '{addr: 4'd15, data: 8'h0F};
`endif

    rst = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_data_out = '0;
    bus.mem_clr = 1'b0;
    bus.rd_addr = '0;
    repeat (3) tick();
    check("rst_rd_data", 32'(bus.rd_data), 32'h0);
    check("rst_count", 32'(bus.mem_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_r_en", 32'(bus.fifo_r_en), 32'd0);
    check("rst_full", 32'(bus.mem_full), 32'd0);

    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.fifo_r_en !== 1'b0) seen++;
    end
    check("idle_no_r_en", 32'(seen), 32'd0);
    check("idle_count", 32'(bus.mem_count), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Two bytes: pops four cycles apart, readback with one-cycle latency.
    pop_cyc.delete();
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_quiet("two", 40);
    check("two_pops", 32'(pop_cyc.size()), 32'd2);
    if (pop_cyc.size() == 2) check("two_spacing", 32'(pop_cyc[1] - pop_cyc[0]), 32'd4);
    check("two_pulse_width", 32'(dbl), 32'd0);
    drain_model();
    check("two_count", 32'(bus.mem_count), 32'd2);
    readback(4'd0, d);
    check("two_rd0", 32'(d), 32'hA5);
    bus.rd_addr = 4'd1;
    #1;
    check("two_rd_latency", 32'(bus.rd_data), 32'hA5);
    tick();
    check("two_rd1", 32'(bus.rd_data), 32'h3C);

    // Twenty bytes against a 16-word memory.
    clear_mem();
    check("clr_count", 32'(bus.mem_count), 32'd0);
    pop_cyc.delete();
    for (int i = 0; i < 20; i++) push_byte(8'(i));
    wait_quiet("fill", 200);
`ifdef MEM_WRAP_EN
    check("fill_pops", 32'(pop_cyc.size()), 32'd20);
    check("fill_full", 32'(bus.mem_full), 32'd0);
`else
    check("fill_pops", 32'(pop_cyc.size()), 32'd16);
    check("fill_full", 32'(bus.mem_full), 32'd1);
    check("fill_fifo_left", 32'(fifo_q.size()), 32'd4);
    if (fifo_q.size() > 0) check("fill_fifo_head", 32'(fifo_q[0]), 32'h10);
`endif
    drain_model();
    check("fill_count", 32'(bus.mem_count), 32'd16);
    check("fill_count_model", 32'(bus.mem_count), 32'(model_cnt));
    for (int i = 0; i < DEPTH; i++) begin
      readback(AW'(i), d);
      check($sformatf("fill_sb_%0d", i), 32'(d), 32'(model_mem[i]));
    end
    for (int i = 0; i < 4; i++) begin
      readback(fill_vec[i].addr, d);
      check($sformatf("fill_vec_%0d", i), 32'(d), 32'(fill_vec[i].data));
    end

`ifdef MEM_WRAP_EN
    clear_mem();
    check("wrap_clr_count", 32'(bus.mem_count), 32'd0);
`else
    clear_mem();
    check("resume_clr_count", 32'(bus.mem_count), 32'd0);
    check("resume_clr_full", 32'(bus.mem_full), 32'd0);
    pop_cyc.delete();
    wait_quiet("resume", 60);
    check("resume_pops", 32'(pop_cyc.size()), 32'd4);
    drain_model();
    check("resume_count", 32'(bus.mem_count), 32'd4);
    readback(4'd0, d);
    check("resume_rd0", 32'(d), 32'h10);
    readback(4'd3, d);
    check("resume_rd3", 32'(d), 32'h13);
`endif

    // Reset while holding 0x77 in CAPT: the word must be lost.
    push_byte(8'h77);
    wait_req("capt", 20);
    tick();
    check("capt_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("capt_rst_busy", 32'(bus.busy), 32'd0);
    tick();
    check("capt_rst_count", 32'(bus.mem_count), 32'd0);
    check("capt_rst_r_en", 32'(bus.fifo_r_en), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    model_ptr = 0;
    model_cnt = 0;
    tick();
    check("capt_after_busy", 32'(bus.busy), 32'd0);
    hits = 0;
    for (int i = 0; i < DEPTH; i++) begin
      readback(AW'(i), d);
      if (d == 8'h77) hits++;
      check($sformatf("capt_keep_%0d", i), 32'(d), 32'(model_mem[i]));
    end
    check("capt_no_77", 32'(hits), 32'd0);

    // Read and write of address 5 in the same cycle returns the old word.
    for (int i = 0; i < 5; i++) push_byte(8'hE0 + 8'(i));
    push_byte(8'h11);
    wait_quiet("old", 60);
    drain_model();
    clear_mem();
    for (int i = 0; i < 5; i++) push_byte(8'hF0 + 8'(i));
    wait_quiet("pre", 60);
    drain_model();
    bus.rd_addr = 4'd5;
    push_byte(8'h5A);
    wait_req("rw", 20);
    tick();
    tick();
    check("rw_in_store", 32'(bus.busy), 32'd1);
    tick();
    check("rw_old", 32'(bus.rd_data), 32'h11);
    tick();
    check("rw_new", 32'(bus.rd_data), 32'h5A);
    wait_quiet("rw", 20);
    drain_model();
    check("rw_count", 32'(bus.mem_count), 32'(model_cnt));
    check("rw_model", 32'(model_mem[5]), 32'h5A);
    check("no_underflow", 32'(underflow), 32'd0);
    check("pulse_width", 32'(dbl), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_slave_writer.md
Name: mem_slave_writer

Overview:
- Memory-side consumer of the async FIFO, running entirely in the clk_mem domain.
- Pops bytes from the FIFO read port whenever the FIFO is non-empty and stores them sequentially into an internal register-file memory.
- Exposes a registered readback port, fill count and full status to the memory-side logic.
- Sits directly downstream of the FIFO's read side (r_en / data_out / empty).

Parameters:
- DATA_WIDTH, 8, width of FIFO data and memory words.
- ADDR_WIDTH, 4, memory address width; DEPTH = 2**ADDR_WIDTH = 16 words.

Ports:
- clk_mem  input  1  memory-domain clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag, clk_mem domain.
- fifo_data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_r_en is sampled high.
- fifo_r_en  output  1  FIFO read enable (pop), one-cycle pulse.
- mem_clr  input  1  synchronous clear of write pointer and count.
- rd_addr  input  ADDR_WIDTH  readback address.
- rd_data  output  DATA_WIDTH  registered readback data.
- mem_count  output  ADDR_WIDTH+1  number of words stored.
- mem_full  output  1  high when mem_count == DEPTH.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE, wr_ptr = 0, mem_count = 0.
  - fifo_r_en = 0, rd_data = 0, mem_full = 0, busy = 0.
  - Memory array contents are not reset.
- FSM states: IDLE, REQ, CAPT, STORE. State is registered; fifo_r_en = (state==REQ) and busy = (state!=IDLE), both decoded from the state register only, so they are glitch-free.
  - IDLE: if !fifo_empty && !mem_full, go to REQ; else stay.
  - REQ: fifo_r_en = 1 for exactly this cycle; go to CAPT.
  - CAPT: latch fifo_data_out into data_reg; go to STORE.
  - STORE: mem[wr_ptr] <= data_reg; wr_ptr <= wr_ptr+1 (modulo DEPTH); mem_count <= mem_count+1; go to IDLE.
- Throughput and latency:
  - One word per 4 cycles.
  - A byte present while in IDLE is visible in memory on the edge ending STORE, 4 edges after leaving IDLE.
  - fifo_empty is sampled only in IDLE. A FIFO going empty during REQ/CAPT/STORE has no effect on the transaction in flight.
- Readback:
  - rd_data <= mem[rd_addr] every cycle; 1-cycle latency.
  - When the read and the STORE write hit the same address in the same cycle, rd_data returns the old contents.
- mem_full:
  - Combinational compare of mem_count against DEPTH.
  - While it is high, no new REQ is issued; FIFO contents are left in place.
- mem_clr, sampled high in any state:
  - wr_ptr = 0, mem_count = 0, state = IDLE next cycle.
  - A word in CAPT/STORE is dropped (already popped from the FIFO; lost).
  - Memory contents are unchanged.
  - mem_clr has priority over STORE.
- Reset mid-transaction: the in-flight word is dropped; no partial write occurs.
- Arithmetic:
  - wr_ptr is ADDR_WIDTH bits and wraps naturally.
  - mem_count is ADDR_WIDTH+1 bits and never exceeds DEPTH.

Optional Feature:
- Macro: MEM_WRAP_EN.
- Defined (ring-buffer mode):
  - mem_full is tied to 0.
  - IDLE issues REQ whenever !fifo_empty.
  - wr_ptr wraps 15->0 and overwrites the oldest word.
  - mem_count saturates at DEPTH (stays 16).
- Undefined:
  - Behaviour exactly as above; writes stop at DEPTH until mem_clr or reset.

Test Plan:
- Reset release with fifo_empty=1 for 10 cycles -> fifo_r_en never asserted; mem_count=0; busy=0; rd_data=0.
- FIFO model holds 0xA5, 0x3C; fifo_empty falls -> fifo_r_en pulses 1 cycle, twice, 4 cycles apart; rd_addr=0 gives 0xA5 and rd_addr=1 gives 0x3C, one cycle after the address is applied; mem_count=2.
- Push 20 bytes 0x00..0x13, macro undefined -> exactly 16 pops; mem_full=1; mem_count=16; mem[15]=0x0F; FIFO retains 0x10..0x13. Pulse mem_clr -> count=0, and pops resume with 0x10 written at addr 0.
- Same 20 bytes with MEM_WRAP_EN -> 20 pops; mem_full=0; mem_count=16; mem[0..3]=0x10..0x13; mem[4]=0x04.
- Assert reset during CAPT holding 0x77 -> next cycle state=IDLE, mem_count=0; 0x77 never appears in memory.
- rd_addr=wr_ptr=5 during a STORE of 0x5A over old 0x11 -> rd_data=0x11 that cycle, 0x5A the following cycle.
